sram_rr_arbiter: RTL and testbench

Two-channel arbiter that shares one 256x16 single-port SRAM between two requesters (channel A, channel B). It accepts per-channel read/write commands over a req/ack handshake, grants one channel at a time, sequences the SRAM enables and captures read data after the SRAM read latency. It sits directly in front of the single-port SRAM and owns all of the SRAM's data, address and enable pins.

---
 rtl/sram_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_sram_rr_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-channel req/ack arbiter that owns a single-port SRAM; one access in flight.
// Optional macro SRAM_ARB_FIXED_PRIORITY_EN: channel A always wins ties and no round-robin pointer exists.
module sram_rr_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  A_Req_In,
  input  logic                  A_Write_In,
  input  logic [ADDR_WIDTH-1:0] A_Address_In,
  input  logic [DATA_WIDTH-1:0] A_Data_In,
  output logic                  A_Ack_Out,
  output logic [DATA_WIDTH-1:0] A_Data_Out,
  input  logic                  B_Req_In,
  input  logic                  B_Write_In,
  input  logic [ADDR_WIDTH-1:0] B_Address_In,
  input  logic [DATA_WIDTH-1:0] B_Data_In,
  output logic                  B_Ack_Out,
  output logic [DATA_WIDTH-1:0] B_Data_Out,
  output logic [DATA_WIDTH-1:0] Sram_Data_Out,
  output logic [ADDR_WIDTH-1:0] Sram_Address_Out,
  output logic                  Sram_Write_Enable_Out,
  output logic                  Sram_Read_Enable_Out,
  input  logic [DATA_WIDTH-1:0] Sram_Data_In,
  output logic                  Busy_Out
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             grant_b;
  logic             win_b;
  logic             cmd_write;
  logic [CNT_W-1:0] lat_cnt;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
  assign grant_b = B_Req_In & ~A_Req_In;
`else
  // ptr_b = 1 means B wins the next tie
  logic ptr_b;
  assign grant_b = B_Req_In & (~A_Req_In | ptr_b);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (A_Req_In || B_Req_In) state_nxt = ISSUE;
      ISSUE:   state_nxt = cmd_write ? RESP : WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      state                 <= IDLE;
      lat_cnt               <= '0;
      win_b                 <= 1'b0;
      cmd_write             <= 1'b0;
      A_Ack_Out             <= 1'b0;
      B_Ack_Out             <= 1'b0;
      A_Data_Out            <= '0;
      B_Data_Out            <= '0;
      Sram_Data_Out         <= '0;
      Sram_Address_Out      <= '0;
      Sram_Write_Enable_Out <= 1'b0;
      Sram_Read_Enable_Out  <= 1'b0;
      Busy_Out              <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
      ptr_b                 <= 1'b0;
`endif
    end else begin
      state                 <= state_nxt;
      Busy_Out              <= (state_nxt != IDLE);
      Sram_Write_Enable_Out <= 1'b0;
      Sram_Read_Enable_Out  <= 1'b0;
      A_Ack_Out             <= 1'b0;
      B_Ack_Out             <= 1'b0;
      case (state)
        // grant: latch the winner's command straight onto the SRAM pins
        IDLE: begin
          if (state_nxt == ISSUE) begin
            win_b                 <= grant_b;
            cmd_write             <= grant_b ? B_Write_In : A_Write_In;
            Sram_Address_Out      <= grant_b ? B_Address_In : A_Address_In;
            Sram_Data_Out         <= grant_b ? B_Data_In : A_Data_In;
            Sram_Write_Enable_Out <= grant_b ? B_Write_In : A_Write_In;
            Sram_Read_Enable_Out  <= grant_b ? ~B_Write_In : ~A_Write_In;
          end
        end
        ISSUE: begin
          lat_cnt <= CNT_W'(READ_LATENCY - 1);
          if (cmd_write) begin
            A_Ack_Out <= ~win_b;
            B_Ack_Out <= win_b;
          end
        end
        // read data is valid on the last wait cycle
        WAIT: begin
          if (lat_cnt == '0) begin
            if (win_b) B_Data_Out <= Sram_Data_In;
            else       A_Data_Out <= Sram_Data_In;
            A_Ack_Out <= ~win_b;
            B_Ack_Out <= win_b;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
          ptr_b <= ~win_b;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: one instance at READ_LATENCY=1, one at READ_LATENCY=3,
// each in front of a small SRAM model of matching latency.
module tb_sram_rr_arbiter;

  logic clk;
  logic rst_n;

  // latency-1 instance
  logic        a_req, a_wr, a_ack, b_req, b_wr, b_ack;
  logic [7:0]  a_addr, b_addr, s_addr;
  logic [15:0] a_wdata, a_rdata, b_wdata, b_rdata, s_wdata, s_rdata;
  logic        s_we, s_re, busy;

  // latency-3 instance
  logic        a3_req, a3_wr, a3_ack, b3_req, b3_wr, b3_ack;
  logic [7:0]  a3_addr, b3_addr, s3_addr;
  logic [15:0] a3_wdata, a3_rdata, b3_wdata, b3_rdata, s3_wdata, s3_rdata;
  logic        s3_we, s3_re, busy3;

  logic [15:0] mem  [256];
  logic [15:0] mem3 [256];
  logic [15:0] p3   [3];

  int n_checks = 0;
  int n_errors = 0;

  sram_rr_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(1)) dut (
    .Clk_In(clk), .Reset_In(rst_n),
    .A_Req_In(a_req), .A_Write_In(a_wr), .A_Address_In(a_addr), .A_Data_In(a_wdata),
    .A_Ack_Out(a_ack), .A_Data_Out(a_rdata),
    .B_Req_In(b_req), .B_Write_In(b_wr), .B_Address_In(b_addr), .B_Data_In(b_wdata),
    .B_Ack_Out(b_ack), .B_Data_Out(b_rdata),
    .Sram_Data_Out(s_wdata), .Sram_Address_Out(s_addr),
    .Sram_Write_Enable_Out(s_we), .Sram_Read_Enable_Out(s_re),
    .Sram_Data_In(s_rdata), .Busy_Out(busy)
  );

  sram_rr_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(3)) dut3 (
    .Clk_In(clk), .Reset_In(rst_n),
    .A_Req_In(a3_req), .A_Write_In(a3_wr), .A_Address_In(a3_addr), .A_Data_In(a3_wdata),
    .A_Ack_Out(a3_ack), .A_Data_Out(a3_rdata),
    .B_Req_In(b3_req), .B_Write_In(b3_wr), .B_Address_In(b3_addr), .B_Data_In(b3_wdata),
    .B_Ack_Out(b3_ack), .B_Data_Out(b3_rdata),
    .Sram_Data_Out(s3_wdata), .Sram_Address_Out(s3_addr),
    .Sram_Write_Enable_Out(s3_we), .Sram_Read_Enable_Out(s3_re),
    .Sram_Data_In(s3_rdata), .Busy_Out(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models; 16'hDEAD appears on the read port whenever no read was issued
  always_ff @(posedge clk) begin
    if (s_we) mem[s_addr] <= s_wdata;
    s_rdata <= s_re ? mem[s_addr] : 16'hDEAD;
  end

  always_ff @(posedge clk) begin
    if (s3_we) mem3[s3_addr] <= s3_wdata;
    p3[0] <= s3_re ? mem3[s3_addr] : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign s3_rdata = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int order [8];
  int n_gr, a_idx, b_idx, exp_ch;

  initial begin
    rst_n = 1'b0;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h3C; a_wdata = 16'hBEEF;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 8'hFF; b_wdata = 16'h5A5A;
    a3_req = 1'b0; a3_wr = 1'b0; a3_addr = 8'h00; a3_wdata = 16'h0000;
    b3_req = 1'b0; b3_wr = 1'b0; b3_addr = 8'h00; b3_wdata = 16'h0000;

    // reset held two cycles with both requests up
    tick(); tick();
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_we", 32'(s_we), 32'd0);
    chk("rst_re", 32'(s_re), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'd0);
    chk("rst_sdata", 32'(s_wdata), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);

    // release: A wins the tie and writes first, then B
    rst_n = 1'b1;
    tick();
    chk("wrA_issue_we", 32'(s_we), 32'd1);
    chk("wrA_issue_re", 32'(s_re), 32'd0);
    chk("wrA_addr", 32'(s_addr), 32'h3C);
    chk("wrA_data", 32'(s_wdata), 32'hBEEF);
    chk("wrA_busy", 32'(busy), 32'd1);
    tick();
    chk("wrA_ack", 32'(a_ack), 32'd1);
    chk("wrA_b_ack", 32'(b_ack), 32'd0);
    chk("wrA_we_once", 32'(s_we), 32'd0);
    a_req = 1'b0;
    tick();
    chk("wrA_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("wrB_issue_we", 32'(s_we), 32'd1);
    chk("wrB_addr", 32'(s_addr), 32'hFF);
    tick();
    chk("wrB_ack", 32'(b_ack), 32'd1);
    chk("wrB_a_ack", 32'(a_ack), 32'd0);
    b_req = 1'b0;
    tick();
    chk("mem_3c", 32'(mem[8'h3C]), 32'hBEEF);
    chk("mem_ff", 32'(mem[8'hFF]), 32'h5A5A);

    // A reads 0x3C back: ack at T+3 for READ_LATENCY=1
    a_req = 1'b1; a_wr = 1'b0;
    tick();
    chk("rdA_issue_re", 32'(s_re), 32'd1);
    chk("rdA_issue_we", 32'(s_we), 32'd0);
    chk("rdA_addr", 32'(s_addr), 32'h3C);
    tick();
    chk("rdA_wait_ack", 32'(a_ack), 32'd0);
    chk("rdA_wait_en", 32'({s_we, s_re}), 32'd0);
    chk("rdA_wait_busy", 32'(busy), 32'd1);
    tick();
    chk("rdA_ack", 32'(a_ack), 32'd1);
    chk("rdA_data", 32'(a_rdata), 32'hBEEF);
    chk("rdA_resp_busy", 32'(busy), 32'd1);
    a_req = 1'b0;
    tick();
    chk("rdA_ack_pulse", 32'(a_ack), 32'd0);
    chk("rdA_data_hold", 32'(a_rdata), 32'hBEEF);
    chk("rdA_idle_busy", 32'(busy), 32'd0);

    // B reads 0xFF, reset lands during WAIT
    b_req = 1'b1; b_wr = 1'b0; b_addr = 8'hFF;
    tick();
    chk("rdB_issue_re", 32'(s_re), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_b_ack", 32'(b_ack), 32'd0);
    chk("midrst_en", 32'({s_we, s_re}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bdata", 32'(b_rdata), 32'd0);
    tick();
    chk("midrst_b_ack2", 32'(b_ack), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rdB_re_again", 32'(s_re), 32'd1);
    tick();
    chk("rdB_wait_ack", 32'(b_ack), 32'd0);
    tick();
    chk("rdB_ack", 32'(b_ack), 32'd1);
    chk("rdB_data", 32'(b_rdata), 32'h5A5A);
    b_req = 1'b0;
    tick();

    // contention: both channels stream writes, A to even and B to odd addresses
    n_gr = 0; a_idx = 0; b_idx = 0;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h00; a_wdata = 16'hA000;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 8'h01; b_wdata = 16'hB001;
    for (int c = 0; c < 80 && n_gr < 8; c++) begin
      tick();
      chk("ack_overlap", 32'(a_ack & b_ack), 32'd0);
      if (a_ack && n_gr < 8) begin
        order[n_gr] = 0; n_gr++; a_idx++;
        if (a_idx == 4) a_req = 1'b0;
        else begin
          a_addr = 8'(2 * a_idx); a_wdata = 16'hA000 + 16'(2 * a_idx);
        end
      end
      if (b_ack && n_gr < 8) begin
        order[n_gr] = 1; n_gr++; b_idx++;
        if (b_idx == 4) b_req = 1'b0;
        else begin
          b_addr = 8'(2 * b_idx + 1); b_wdata = 16'hB000 + 16'(2 * b_idx + 1);
        end
      end
    end
    chk("grant_count", 32'(n_gr), 32'd8);
    for (int k = 0; k < n_gr; k++) begin
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
      exp_ch = (k >= 4) ? 1 : 0;
`else
      exp_ch = k % 2;
`endif
      chk("grant_order", 32'(order[k]), 32'(exp_ch));
    end
    tick(); tick();
    for (int i = 0; i < 8; i++)
      chk("mem_dump", 32'(mem[8'(i)]), (i % 2 == 1) ? 32'hB000 + 32'(i) : 32'hA000 + 32'(i));

    // READ_LATENCY=3 instance: write 0x42 then read it, ack at T+5
    a3_req = 1'b1; a3_wr = 1'b1; a3_addr = 8'h42; a3_wdata = 16'hC0DE;
    tick();
    chk("l3_wr_we", 32'(s3_we), 32'd1);
    tick();
    chk("l3_wr_ack", 32'(a3_ack), 32'd1);
    a3_req = 1'b0;
    tick();
    a3_req = 1'b1; a3_wr = 1'b0;
    tick();
    chk("l3_rd_re", 32'(s3_re), 32'd1);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("l3_wait_ack", 32'(a3_ack), 32'd0);
      chk("l3_wait_busy", 32'(busy3), 32'd1);
      chk("l3_wait_en", 32'({s3_we, s3_re}), 32'd0);
    end
    tick();
    chk("l3_ack", 32'(a3_ack), 32'd1);
    chk("l3_data", 32'(a3_rdata), 32'hC0DE);
    a3_req = 1'b0;
    tick();
    chk("l3_ack_pulse", 32'(a3_ack), 32'd0);
    chk("l3_idle_busy", 32'(busy3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
